fft16_frame_ctrl: RTL and testbench

- Frame sequencer for the 16-point butterfly datapath.
- Accepts complex samples serially over a valid/ready stream and assembles 16-sample frames.
- Presents each frame in parallel to the datapath with a start pulse, waits the fixed pipeline latency, captures the 16 results, and streams them out serially.
- An input frame may be collected while the previous result frame drains.

---
 rtl/fft16_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_fft16_frame_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fft16_frame_ctrl.sv
// fft16_frame_ctrl: frame sequencer for the 16-point butterfly datapath.
//   Collects 16 complex samples from a valid/ready input stream. It then
//   presents the frame in parallel with a one-cycle dp_start pulse. It waits
//   LAT cycles, captures the 16 results, and streams them out serially. The
//   next input frame can be collected while the current result frame drains.
// Ports:
//   clk, rst              clock / synchronous active-high reset
//   s_valid/s_ready       input handshake; s_real, s_imag data; s_last check
//   dp_start              issue pulse; dp_x_* parallel frame (slot i at i*DW)
//   dp_y_*                datapath results, valid LAT cycles after dp_start
//   m_valid/m_ready       output handshake; m_real, m_imag, m_index, m_last
//   busy                  a frame is in ISSUE/WAIT/DRAIN
//   err_framing           sticky s_last position mismatch
module fft16_frame_ctrl #(
  parameter int DW         = 32,
  parameter int LAT        = 3,
  parameter int BITREV_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_real,
  input  logic [DW-1:0]    s_imag,
  input  logic             s_last,
  output logic             dp_start,
  output logic [16*DW-1:0] dp_x_real,
  output logic [16*DW-1:0] dp_x_imag,
  input  logic [16*DW-1:0] dp_y_real,
  input  logic [16*DW-1:0] dp_y_imag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_real,
  output logic [DW-1:0]    m_imag,
  output logic [3:0]       m_index,
  output logic             m_last,
  output logic             busy,
  output logic             err_framing
);

  localparam int LW = $clog2(LAT + 1) + 1;

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic                   in_full_q, in_full_d;
  logic                   err_q, err_d;
  logic [LW-1:0]          lat_cnt_q, lat_cnt_d;
  logic [15:0][DW-1:0]    in_re_q, in_re_d, in_im_q, in_im_d;
  logic [15:0][DW-1:0]    out_re_q, out_re_d, out_im_q, out_im_d;
  logic                   s_acc, m_acc, capture;
  logic [3:0]             rd_idx;

  // in_full_q is a flop; rst gating keeps s_ready low for every reset cycle.
  assign s_ready  = !in_full_q && !rst;
  assign s_acc    = s_valid && s_ready;
  assign m_acc    = m_valid && m_ready;
  assign capture  = (state_q == WAIT) && (lat_cnt_q == LW'(LAT));

  // The input buffer stays untouched from ISSUE until capture, so dp_x_* can
  // come straight from it.
  assign dp_x_real   = in_re_q;
  assign dp_x_imag   = in_im_q;
  assign err_framing = err_q;

  // Input path: write pointer, full flag, framing check.
  always_comb begin
    wcnt_d    = wcnt_q;
    in_full_d = in_full_q;
    err_d     = err_q;
    in_re_d   = in_re_q;
    in_im_d   = in_im_q;
    if (capture) in_full_d = 1'b0;
    if (s_acc) begin
      in_re_d[wcnt_q] = s_real;
      in_im_d[wcnt_q] = s_imag;
      wcnt_d          = wcnt_q + 4'd1;
      if (wcnt_q == 4'd15) in_full_d = 1'b1;
      if (s_last != (wcnt_q == 4'd15)) err_d = 1'b1;
    end
  end

  // Latency counter, result capture, read pointer.
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    rcnt_d    = rcnt_q;
    out_re_d  = out_re_q;
    out_im_d  = out_im_q;
    if (state_q == ISSUE)     lat_cnt_d = LW'(1);
    else if (state_q == WAIT) lat_cnt_d = lat_cnt_q + LW'(1);
    if (capture) begin
      out_re_d = dp_y_real;
      out_im_d = dp_y_imag;
      rcnt_d   = 4'd0;
    end
    if (m_acc) rcnt_d = rcnt_q + 4'd1;
  end

  // Next state. in_full_d is used so that a frame completing this cycle
  // (from FILL, or on the final drain beat) issues with no idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (in_full_d) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (capture) state_d = DRAIN;
      DRAIN:   if (m_acc && rcnt_q == 4'd15) state_d = in_full_d ? ISSUE : FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs.
  always_comb begin
    dp_start = (state_q == ISSUE);
    busy     = (state_q != FILL);
    m_valid  = (state_q == DRAIN);
    m_index  = rcnt_q;
    m_last   = m_valid && (rcnt_q == 4'd15);
    if (BITREV_OUT != 0) rd_idx = {rcnt_q[0], rcnt_q[1], rcnt_q[2], rcnt_q[3]};
    else                 rd_idx = rcnt_q;
    m_real   = out_re_q[rd_idx];
    m_imag   = out_im_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      in_full_q <= 1'b0;
      err_q     <= 1'b0;
      lat_cnt_q <= '0;
      in_re_q   <= '0;
      in_im_q   <= '0;
      out_re_q  <= '0;
      out_im_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      in_full_q <= in_full_d;
      err_q     <= err_d;
      lat_cnt_q <= lat_cnt_d;
      in_re_q   <= in_re_d;
      in_im_q   <= in_im_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
    end
  end

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Bench for fft16_frame_ctrl: natural-order and bit-reversed instances share
// one stimulus stream. A frame-level timing/data model predicts every output
// each cycle. The datapath stand-in returns x+1 only in the exact result cycle.
module tb_fft16_frame_ctrl;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int FW  = 16 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] s_real = '0, s_imag = '0;
  logic [FW-1:0] dp_y_real = '0, dp_y_imag = '0;

  logic          s_ready0, dp_start0, m_valid0, m_last0, busy0, err0;
  logic          s_ready1, dp_start1, m_valid1, m_last1, busy1, err1;
  logic [FW-1:0] dp_x_real0, dp_x_imag0, dp_x_real1, dp_x_imag1;
  logic [DW-1:0] m_real0, m_imag0, m_real1, m_imag1;
  logic [3:0]    m_index0, m_index1;

  fft16_frame_ctrl #(.DW(DW), .LAT(LAT), .BITREV_OUT(0)) u_nat (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
    .s_real(s_real), .s_imag(s_imag), .s_last(s_last), .dp_start(dp_start0),
    .dp_x_real(dp_x_real0), .dp_x_imag(dp_x_imag0),
    .dp_y_real(dp_y_real), .dp_y_imag(dp_y_imag),
    .m_valid(m_valid0), .m_ready(m_ready), .m_real(m_real0), .m_imag(m_imag0),
    .m_index(m_index0), .m_last(m_last0), .busy(busy0), .err_framing(err0));

  fft16_frame_ctrl #(.DW(DW), .LAT(LAT), .BITREV_OUT(1)) u_rev (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1),
    .s_real(s_real), .s_imag(s_imag), .s_last(s_last), .dp_start(dp_start1),
    .dp_x_real(dp_x_real1), .dp_x_imag(dp_x_imag1),
    .dp_y_real(dp_y_real), .dp_y_imag(dp_y_imag),
    .m_valid(m_valid1), .m_ready(m_ready), .m_real(m_real1), .m_imag(m_imag1),
    .m_index(m_index1), .m_last(m_last1), .busy(busy1), .err_framing(err1));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int br4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  function automatic logic [FW-1:0] pack(input logic [DW-1:0] a [16], input logic [DW-1:0] add);
    logic [FW-1:0] r;
    for (int j = 0; j < 16; j++) r[j*DW +: DW] = a[j] + add;
    return r;
  endfunction

  // Frame-level model state. "Current cycle" is cyc between negedges.
  int            cyc = 0, in_cnt = 0, k = 0, issue_at = -1, cap_at = -1;
  logic          blocked = 0, out_busy = 0, out_active = 0, wait_issue = 0, err_exp = 0;
  logic [DW-1:0] bre [16], bim [16], cre [16], cim [16];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("s_ready_in_reset", {s_ready1, s_ready0}, 2'b00);
      in_cnt = 0; k = 0; issue_at = -1; cap_at = -1;
      blocked = 0; out_busy = 0; out_active = 0; wait_issue = 0; err_exp = 0;
      dp_y_real = {16{$urandom}};
      dp_y_imag = {16{$urandom}};
    end else begin
      chk("s_ready", {s_ready1, s_ready0}, {2{!blocked}});
      chk("dp_start", {dp_start1, dp_start0}, {2{cyc == issue_at}});
      if (cyc == issue_at) begin
        chk("dp_x_real", dp_x_real0, pack(bre, '0));
        chk("dp_x_imag", dp_x_imag1, pack(bim, '0));
      end
      chk("busy", {busy1, busy0}, {2{out_busy}});
      chk("err_framing", {err1, err0}, {2{err_exp}});
      chk("m_valid", {m_valid1, m_valid0}, {2{out_active}});
      if (out_active) begin
        chk("m_index", {m_index1, m_index0}, {2{4'(k)}});
        chk("m_last", {m_last1, m_last0}, {2{k == 15}});
        chk("m_real_nat", m_real0, cre[k]);
        chk("m_imag_nat", m_imag0, cim[k]);
        chk("m_real_rev", m_real1, cre[br4(k)]);
        chk("m_imag_rev", m_imag1, cim[br4(k)]);
      end
      // End-of-cycle events: output beat first, then input beat.
      if (out_active && m_ready) begin
        k++;
        if (k == 16) begin
          k = 0; out_active = 0; out_busy = 0;
          if (wait_issue) begin
            issue_at = cyc + 1; out_busy = 1; wait_issue = 0;
          end
        end
      end
      if (s_valid && !blocked) begin
        bre[in_cnt] = s_real;
        bim[in_cnt] = s_imag;
        if (s_last != (in_cnt == 15)) err_exp = 1;
        in_cnt++;
        if (in_cnt == 16) begin
          in_cnt = 0; blocked = 1;
          if (!out_busy) begin
            issue_at = cyc + 1; out_busy = 1;
          end else wait_issue = 1;
        end
      end
      if (cyc == issue_at) cap_at = cyc + LAT;
      if (cyc == cap_at) begin
        dp_y_real = pack(bre, 1);
        dp_y_imag = pack(bim, 1);
        for (int j = 0; j < 16; j++) begin
          cre[j] = bre[j] + 1;
          cim[j] = bim[j] + 1;
        end
        blocked = 0; out_active = 1; k = 0;
      end else begin
        dp_y_real = {16{$urandom}};
        dp_y_imag = {16{$urandom}};
      end
    end
  end

  logic inject = 0;

  task automatic step(input int pv, input int pr);
    s_valid = ($urandom_range(99) < pv);
    s_real  = $urandom;
    s_imag  = $urandom;
    s_last  = (in_cnt == 15) || (inject && in_cnt == 7);
    m_ready = ($urandom_range(99) < pr);
    @(posedge clk); #1;
    if (inject && in_cnt > 7) inject = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Directed frame: real=i, imag=100+i, drained at full rate.
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_real = DW'(i); s_imag = DW'(100 + i);
      s_last = (i == 15); m_ready = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    // Back-to-back frames at full throughput.
    repeat (120) step(100, 100);
    // Random valid/ready with stalls.
    repeat (400) step(70, 50);
    // Early s_last on beat 7.
    inject = 1;
    repeat (200) step(80, 60);
    // Reset while waiting on the datapath.
    n = 0;
    while (!(issue_at >= 0 && cyc >= issue_at && cyc < issue_at + LAT && !out_active) && n < 300) begin
      step(80, 100); n++;
    end
    chk("reached_wait", n < 300, 1);
    pulse_reset();
    // Reset in the middle of a drain (rcnt=5).
    n = 0;
    while (!(out_active && k == 5) && n < 300) begin
      step(80, 50); n++;
    end
    chk("reached_drain5", n < 300, 1);
    pulse_reset();
    repeat (400) step(70, 70);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
